// File: rtl/grid_row_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | grid_row_fetcher: Avalon-MM read master that scans the playfield row by    |
// | row into a shadow buffer and publishes it only after a complete scan.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module grid_row_fetcher #(
  parameter int ROWS    = 20,
  parameter int COLS    = 10,
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [ROWS*COLS-1:0]   grid_out,
  output logic [ADDR_W-1:0]      avm_address,
  output logic                   avm_read,
  input  logic                   avm_waitrequest,
  input  logic [31:0]            avm_readdata,
  input  logic                   avm_readdatavalid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REQ    = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]   T_LIMIT  = TW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  logic [1:0]            state;
  logic [ADDR_W-1:0]     row;
  logic [TW-1:0]         tcnt;
  logic [ROWS*COLS-1:0]  shadow;

  // Only the low COLS bits of a row word carry grid cells.
  logic unused_readdata_hi;
  assign unused_readdata_hi = ^avm_readdata[31:COLS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      row         <= '0;
      tcnt        <= '0;
      shadow      <= '0;
      grid_out    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      avm_read    <= 1'b0;
      avm_address <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_REQ;
            row         <= '0;
            avm_address <= '0;
            avm_read    <= 1'b1;
            busy        <= 1'b1;
          end
        end
        S_REQ: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            tcnt     <= '0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          tcnt <= tcnt + TW'(1);
          // A response on the last allowed cycle still wins over the abort.
          if (avm_readdatavalid) begin
            shadow[int'(row)*COLS +: COLS] <= avm_readdata[COLS-1:0];
            if (row == LAST_ROW) begin
              state <= S_FINISH;
            end else begin
              row         <= row + ADDR_W'(1);
              avm_address <= row + ADDR_W'(1);
              avm_read    <= 1'b1;
              state       <= S_REQ;
            end
          end else if (tcnt == T_LIMIT) begin
            state <= S_IDLE;
            err   <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_FINISH: begin
          grid_out <= shadow;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_grid_row_fetcher.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for grid_row_fetcher: behavioural Avalon slave plus scan-level reference model.
module tb_grid_row_fetcher;
  localparam int ROWS = 20, COLS = 10, ADDR_W = 5, TIMEOUT = 64;
  localparam int GW = ROWS * COLS;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              busy, done, err;
  logic [GW-1:0]     grid_out;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_waitrequest = 1'b0;
  logic [31:0]       avm_readdata = '0;
  logic              avm_readdatavalid = 1'b0;

  always #5 clk = ~clk;

  grid_row_fetcher #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .grid_out(grid_out), .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  typedef struct {
    int pat; int lat; int stall_addr; int stall_len; int drop; int extra;
    int exp_done; int exp_err; int exp_lat; int exp_reads;
  } vec_t;

  int vectors = 0, miscompares = 0;
  int cyc = 0, req_cyc = 0, req_gap = 0, done_cyc = 0, err_cyc = 0;
  int done_cnt = 0, err_cnt = 0, acc_cnt = 0, scan_acc = 0;
  int lat_cfg = 1, stall_addr = -1, stall_left = 0, drop_addr = -1, extra_off = -1, reset_row = -1;
  int rst_phase = 0, due = 0, pend_addr = 0;
  bit kick = 1'b0, pend = 1'b0, prev_busy = 1'b0, prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [31:0]       rowdata [ROWS];
  logic [GW-1:0]     model_grid = '0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [GW-1:0] grid_model();
    logic [GW-1:0] g;
    g = '0;
    for (int r = 0; r < ROWS; r++) g[r*COLS +: COLS] = rowdata[r][COLS-1:0];
    return g;
  endfunction

  // Slave model, stimulus driver and event monitor, all evaluated mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (busy && !prev_busy) begin req_gap = cyc - done_cyc; req_cyc = cyc; scan_acc = 0; end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (err) begin err_cnt++; err_cyc = cyc; end
    if (prev_stall) begin
      chk("stall_read_held", avm_read, 1);
      chk("stall_addr_held", avm_address, prev_addr);
    end
    if (rst_phase == 2) begin
      chk("midreset_busy", busy, 0);
      chk("midreset_read", avm_read, 0);
      chk("midreset_grid", grid_out, 0);
      rst_phase = 0;
    end
    reset = (cyc < 4) || (rst_phase == 1);
    if (rst_phase == 1) begin rst_phase = 2; pend = 1'b0; end

    start = 1'b0;
    if (kick) begin start = 1'b1; kick = 1'b0; end
    else if (extra_off >= 0 && cyc == req_cyc + extra_off) begin start = 1'b1; extra_off = -1; end

    avm_readdatavalid = 1'b0;
    avm_readdata = $urandom;
    if (pend && cyc == due) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = rowdata[pend_addr];
      pend = 1'b0;
    end else if (!pend && (!busy || avm_read) && $urandom_range(3) == 0) begin
      avm_readdatavalid = 1'b1;
    end

    avm_waitrequest = 1'b0;
    if (avm_read) begin
      if (int'(avm_address) == stall_addr && stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        chk("addr_order", avm_address, scan_acc);
        scan_acc++;
        acc_cnt++;
        if (int'(avm_address) == reset_row) begin rst_phase = 1; reset_row = -1; end
        if (int'(avm_address) != drop_addr) begin
          pend = 1'b1; due = cyc + lat_cfg; pend_addr = int'(avm_address);
        end
      end
    end
    prev_stall = avm_read && avm_waitrequest;
    prev_addr = avm_address;
    prev_busy = busy;
  end

  task automatic fill_rows(input int pat);
    for (int r = 0; r < ROWS; r++) begin
      case (pat)
        1: rowdata[r] = (r == 0) ? 32'h0000_03FF : 32'h0;
        2: rowdata[r] = {22'h3FFFFF, 10'(r + 1)};
        default: rowdata[r] = $urandom;
      endcase
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int d0, e0, a0, seen;
    bit fin;
    fill_rows(v.pat);
    lat_cfg = v.lat; stall_addr = v.stall_addr; stall_left = v.stall_len;
    drop_addr = v.drop; extra_off = v.extra;
    d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
    kick = 1'b1;
    fin = 1'b0;
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(posedge clk); #1;
      if (done_cnt != d0 || err_cnt != e0) fin = 1'b1;
    end
    chk({tag, "_ended"}, fin, 1);
    repeat (4) @(posedge clk);
    #1;
    if (v.exp_done != 0) model_grid = grid_model();
    seen = (v.exp_done != 0) ? done_cyc - req_cyc : err_cyc - req_cyc;
    chk({tag, "_done_pulses"}, done_cnt - d0, v.exp_done);
    chk({tag, "_err_pulses"}, err_cnt - e0, v.exp_err);
    chk({tag, "_latency"}, seen, v.exp_lat);
    chk({tag, "_reads"}, acc_cnt - a0, v.exp_reads);
    chk({tag, "_grid"}, grid_out, model_grid);
    chk({tag, "_idle"}, busy, 0);
    stall_left = 0; drop_addr = -1; extra_off = -1;
  endtask

  vec_t vecs [12];

  initial begin
    int d0, e0, a0;
    bit fin;
    vecs[0]  = '{1, 1, -1, 0, -1, -1, 1, 0, 41, 20};
    vecs[1]  = '{2, 1, -1, 0, -1, -1, 1, 0, 41, 20};
    vecs[2]  = '{0, 1,  7, 3, -1, -1, 1, 0, 44, 20};
    vecs[3]  = '{0, 1, -1, 0,  5, -1, 0, 1, 75, 6};
    vecs[4]  = '{0, 2, -1, 0, -1, -1, 1, 0, 61, 20};
    vecs[5]  = '{0, 1, -1, 0, -1, 20, 1, 0, 41, 20};
    vecs[6]  = '{0, 1, -1, 0, -1, 40, 1, 0, 41, 20};
    vecs[7]  = '{0, 3,  0, 5, -1, -1, 1, 0, 86, 20};
    vecs[8]  = '{0, 64, -1, 0, -1, -1, 1, 0, 1301, 20};
    vecs[9]  = '{0, 65, -1, 0, -1, -1, 0, 1, 65, 1};
    vecs[10] = '{0, 1, 19, 2, -1, -1, 1, 0, 43, 20};
    vecs[11] = '{0, 1, -1, 0, 19, -1, 0, 1, 103, 20};
    for (int r = 0; r < ROWS; r++) rowdata[r] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_read", avm_read, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_grid", grid_out, 0);
    repeat (4) @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // New scan launched on the first IDLE cycle after FINISH.
    fill_rows(0);
    lat_cfg = 1; extra_off = 41;
    d0 = done_cnt; a0 = acc_cnt;
    kick = 1'b1;
    fin = 1'b0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(posedge clk); #1;
      if (done_cnt >= d0 + 2) fin = 1'b1;
    end
    repeat (4) @(posedge clk);
    #1;
    model_grid = grid_model();
    chk("b2b_done_pulses", done_cnt - d0, 2);
    chk("b2b_restart_gap", req_gap, 1);
    chk("b2b_latency", done_cyc - req_cyc, 41);
    chk("b2b_reads", acc_cnt - a0, 40);
    chk("b2b_grid", grid_out, model_grid);

    // Reset while waiting for row 12.
    fill_rows(0);
    lat_cfg = 3; reset_row = 12;
    d0 = done_cnt; e0 = err_cnt; a0 = acc_cnt;
    kick = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    model_grid = '0;
    chk("midreset_no_done", done_cnt - d0, 0);
    chk("midreset_no_err", err_cnt - e0, 0);
    chk("midreset_reads", acc_cnt - a0, 13);
    chk("midreset_idle", busy, 0);
    run_vec(vecs[0], "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no summary expected summary before time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/grid_row_fetcher.md
Name: grid_row_fetcher

Overview:
- Avalon-MM read master that scans a 10x20 playfield grid exposed by a row-addressed Avalon-MM slave, one row per read, and reassembles it into a 200-bit flat grid vector.
- Sits between the CPU-side grid register bank and on-fabric consumers (VGA renderer, line-clear checker) that need a coherent copy of the full grid.
- Publishes a new grid only when a full, error-free scan completes, so consumers never see a partial frame.

Parameters:
- ROWS, 20, number of grid rows read per scan
- COLS, 10, valid bits per row, taken from readdata[COLS-1:0]
- ADDR_W, 5, address width, must satisfy 2**ADDR_W >= ROWS
- TIMEOUT, 64, cycles allowed from read acceptance to readdatavalid before abort

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a scan, ignored while busy
- busy  out  1  high from the cycle after an accepted start until the scan ends
- done  out  1  one-cycle pulse when grid_out has been updated
- err  out  1  one-cycle pulse when a scan aborts on timeout
- grid_out  out  ROWS*COLS  last complete grid; row r occupies bits [r*COLS +: COLS]
- avm_address  out  ADDR_W  row index being read
- avm_read  out  1  read request
- avm_waitrequest  in  1  slave stall; the request must be held while this is high
- avm_readdata  in  32  row data; bits [31:COLS] are ignored
- avm_readdatavalid  in  1  avm_readdata is valid this cycle

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: busy=0, done=0, err=0, avm_read=0, avm_address=0, grid_out=0, internal shadow buffer=0, row counter=0, timeout counter=0. FSM returns to IDLE.
- Reset mid-scan: reset abandons the scan immediately. No done or err pulse. grid_out is cleared to 0.
- FSM states: IDLE, REQ, WAIT, FINISH.
- IDLE:
  - start=1 moves the FSM to REQ next cycle.
  - On that transition: row counter=0, avm_address=0, busy=1.
- REQ:
  - avm_read=1 and avm_address=row counter.
  - Address and read are held stable while avm_waitrequest=1.
  - In the first cycle with avm_waitrequest=0, the read is accepted. Next state is WAIT with avm_read=0 and the timeout counter cleared.
- WAIT:
  - avm_read=0 and avm_address held. The timeout counter increments every cycle.
  - On avm_readdatavalid=1, shadow[row*COLS +: COLS] is written with avm_readdata[COLS-1:0].
  - If row == ROWS-1, go to FINISH. Otherwise increment row and go to REQ.
  - If the timeout counter reaches TIMEOUT-1 without readdatavalid, abort: go to IDLE, pulse err for one cycle, busy=0, grid_out unchanged.
- FINISH (one cycle):
  - grid_out <= shadow, done=1, busy=0, next state IDLE.
  - done and the grid_out update are visible in the same cycle.
- Outstanding reads: only one read is in flight at a time; there is no pipelining.
  - Minimum scan latency with a zero-wait, latency-1 slave is 2 cycles per row.
  - The full scan takes 40 cycles plus 1 FINISH cycle from REQ entry.
- start handling:
  - start while busy=1 is ignored and is not queued.
  - start in the FINISH cycle is also ignored.
  - start in IDLE on the cycle immediately after FINISH begins a new scan.
- readdatavalid outside WAIT: ignored; no buffer write, no state change.
- Width rule: the row counter and avm_address are ADDR_W bits wide. Addresses never exceed ROWS-1, so no wrap-around occurs.
- Ordering: row 0 is read first at address 0. Row 19 is read last and occupies grid_out[199:190].

Test Plan:
- Basic scan: slave returns 32'h000003FF for address 0 and 32'h0 elsewhere, zero waitrequest, latency 1; pulse start -> done pulses exactly 41 cycles after REQ entry, grid_out[9:0]=10'h3FF, all other bits 0.
- Upper-bit masking and ordering: slave returns {22'h3FFFFF, addr*10+something} with row r returning 10'(r+1) in the low bits -> grid_out[r*10 +: 10]=r+1 for r=0..19, upper readdata bits absent from grid_out.
- Waitrequest stall: slave holds waitrequest=1 for 3 cycles on address 7 -> avm_read and avm_address=7 stay stable for 4 cycles, one read is accepted, final grid is correct, done is delayed by 3 cycles.
- Timeout: slave never asserts readdatavalid for address 5 -> err pulses once TIMEOUT cycles after acceptance, busy drops, done does not pulse, grid_out retains the previous scan's value.
- Start while busy: pulse start again at row 10 -> exactly 20 reads are issued and exactly one done pulse occurs; a start on the cycle after FINISH begins a new scan at address 0.
- Reset mid-scan: assert reset during WAIT on row 12 -> next cycle busy=0, avm_read=0, grid_out=0, no done or err pulse; a subsequent start completes normally.
